// File: rtl/acc_sequencer.sv
// Sequences one accumulator command through bus grant, operand load, execute
// and result store. All accumulator and bus controls are Moore decodes of the state register.
module acc_sequencer #(
  parameter int OPCODE_WIDTH = 5,
  parameter int STATUS_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_op,
  input  logic                    cmd_load,
  input  logic                    cmd_store,
  output logic                    bus_req,
  input  logic                    bus_gnt,
  output logic                    acc_cs,
  output logic                    acc_we,
  output logic                    acc_oe,
  output logic                    acc_opcode_le,
  output logic [OPCODE_WIDTH-1:0] acc_opcode,
  input  logic [STATUS_WIDTH-1:0] alu_status,
  output logic [STATUS_WIDTH-1:0] status_q,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, WAIT_GNT, LOAD, EXEC, STORE} state_t;

  state_t                  state, state_nxt;
  logic [OPCODE_WIDTH-1:0] op_r;
  logic                    load_r, store_r;
  logic                    accept;
  logic                    done_nxt;

  assign accept = cmd_valid && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      load_r   <= 1'b0;
      store_r  <= 1'b0;
      done     <= 1'b0;
      status_q <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (accept) begin
        load_r  <= cmd_load;
        store_r <= cmd_store;
      end
      if (state == EXEC) status_q <= alu_status;
    end
  end

  // Opcode is pure data: only ever observed in EXEC, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) op_r <= cmd_op;
  end

  always_comb begin
    state_nxt     = state;
    done_nxt      = 1'b0;
    cmd_ready     = 1'b0;
    bus_req       = 1'b0;
    acc_cs        = 1'b0;
    acc_we        = 1'b0;
    acc_oe        = 1'b0;
    acc_opcode_le = 1'b0;
    acc_opcode    = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_load || cmd_store) ? WAIT_GNT : EXEC;
      end
      WAIT_GNT: begin
        bus_req = 1'b1;
        if (bus_gnt) state_nxt = load_r ? LOAD : EXEC;
      end
      LOAD: begin
        bus_req   = 1'b1;
        acc_cs    = 1'b1;
        acc_we    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        // Bus stays held across EXEC so a following STORE never re-arbitrates.
        bus_req       = load_r || store_r;
        acc_opcode_le = 1'b1;
        acc_opcode    = op_r;
        state_nxt     = store_r ? STORE : IDLE;
        done_nxt      = !store_r;
      end
      STORE: begin
        bus_req   = 1'b1;
        acc_cs    = 1'b1;
        acc_oe    = 1'b1;
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed, table-driven bench for acc_sequencer: one row per clock cycle with
// the inputs for that cycle and the Moore/registered outputs expected during it.
module tb_acc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_op = '0;
  logic       cmd_load = 1'b0;
  logic       cmd_store = 1'b0;
  logic       bus_req;
  logic       bus_gnt = 1'b0;
  logic       acc_cs, acc_we, acc_oe, acc_opcode_le;
  logic [4:0] acc_opcode;
  logic [3:0] alu_status = '0;
  logic [3:0] status_q;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  acc_sequencer #(.OPCODE_WIDTH(5), .STATUS_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_load(cmd_load), .cmd_store(cmd_store),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .acc_cs(acc_cs), .acc_we(acc_we), .acc_oe(acc_oe),
    .acc_opcode_le(acc_opcode_le), .acc_opcode(acc_opcode),
    .alu_status(alu_status), .status_q(status_q), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  op;
    logic        ld, st, gnt;
    logic [3:0]  alu;
    logic [15:0] exp;
  } vec_t;

  // Output packing: {ready, bus_req, cs, we, oe, opcode_le, done, opcode[4:0], status_q[3:0]}
  function automatic logic [15:0] ex(logic rdy, logic bus, logic cs, logic we, logic oe,
                                     logic le, logic dn, logic [4:0] opc, logic [3:0] sq);
    return {rdy, bus, cs, we, oe, le, dn, opc, sq};
  endfunction

  function automatic vec_t mk(logic v, logic [4:0] op, logic ld, logic st, logic gnt,
                              logic [3:0] alu, logic [15:0] e);
    vec_t r;
    r.v = v; r.op = op; r.ld = ld; r.st = st; r.gnt = gnt; r.alu = alu; r.exp = e;
    return r;
  endfunction

  function automatic logic [15:0] outs();
    return {cmd_ready, bus_req, acc_cs, acc_we, acc_oe, acc_opcode_le, done, acc_opcode, status_q};
  endfunction

  // Called just after a falling edge: drive, check mid-cycle, advance one cycle.
  task automatic run(input vec_t v, input string tag);
    logic [15:0] got;
    cmd_valid = v.v; cmd_op = v.op; cmd_load = v.ld; cmd_store = v.st;
    bus_gnt = v.gnt; alu_status = v.alu;
    #1;
    got = outs();
    n_tests++;
    if (got !== v.exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, v.exp);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] want);
    logic [15:0] got;
    got = outs();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Per-cycle invariants: write/output enables exclusive, opcode only while latched, done one cycle wide.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    n_tests++;
    if (acc_we && acc_oe) begin
      n_fail++;
      $display("FAIL we_oe_excl got we=%b oe=%b want not both", acc_we, acc_oe);
    end
    n_tests++;
    if (!acc_opcode_le && acc_opcode != 5'd0) begin
      n_fail++;
      $display("FAIL opcode_idle got=%h want=0", acc_opcode);
    end
    n_tests++;
    if (done && prev_done) begin
      n_fail++;
      $display("FAIL done_width got two consecutive done cycles want one");
    end
    prev_done = done;
  end

  vec_t tbl[24];
  vec_t post[6];

  initial begin
    // Load+store, op 3, grant already high
    tbl[0]  = mk(1, 5'd3, 1, 1, 1, 4'h0, ex(1,0,0,0,0,0,0, 5'd0, 4'h0));
    tbl[1]  = mk(0, 5'd0, 0, 0, 1, 4'h0, ex(0,1,0,0,0,0,0, 5'd0, 4'h0));
    tbl[2]  = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(0,1,1,1,0,0,0, 5'd0, 4'h0));
    tbl[3]  = mk(0, 5'd0, 0, 0, 0, 4'hA, ex(0,1,0,0,0,1,0, 5'd3, 4'h0));
    tbl[4]  = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(0,1,1,0,1,0,0, 5'd0, 4'hA));
    tbl[5]  = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(1,0,0,0,0,0,1, 5'd0, 4'hA));
    // No bus, op 1
    tbl[6]  = mk(1, 5'd1, 0, 0, 0, 4'h0, ex(1,0,0,0,0,0,0, 5'd0, 4'hA));
    tbl[7]  = mk(0, 5'd0, 0, 0, 0, 4'h5, ex(0,0,0,0,0,1,0, 5'd1, 4'hA));
    tbl[8]  = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(1,0,0,0,0,0,1, 5'd0, 4'h5));
    // Load only, op 2, grant delayed three cycles
    tbl[9]  = mk(1, 5'd2, 1, 0, 0, 4'h0, ex(1,0,0,0,0,0,0, 5'd0, 4'h5));
    tbl[10] = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(0,1,0,0,0,0,0, 5'd0, 4'h5));
    tbl[11] = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(0,1,0,0,0,0,0, 5'd0, 4'h5));
    tbl[12] = mk(0, 5'd0, 0, 0, 1, 4'h0, ex(0,1,0,0,0,0,0, 5'd0, 4'h5));
    tbl[13] = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(0,1,1,1,0,0,0, 5'd0, 4'h5));
    tbl[14] = mk(0, 5'd0, 0, 0, 0, 4'h3, ex(0,1,0,0,0,1,0, 5'd2, 4'h5));
    tbl[15] = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(1,0,0,0,0,0,1, 5'd0, 4'h3));
    // Store-only op 4 then op 7 with cmd_valid held throughout
    tbl[16] = mk(1, 5'd4, 0, 1, 1, 4'h0, ex(1,0,0,0,0,0,0, 5'd0, 4'h3));
    tbl[17] = mk(1, 5'd7, 0, 0, 1, 4'h0, ex(0,1,0,0,0,0,0, 5'd0, 4'h3));
    tbl[18] = mk(1, 5'd7, 0, 0, 1, 4'h9, ex(0,1,0,0,0,1,0, 5'd4, 4'h3));
    tbl[19] = mk(1, 5'd7, 0, 0, 1, 4'h0, ex(0,1,1,0,1,0,0, 5'd0, 4'h9));
    tbl[20] = mk(1, 5'd7, 0, 0, 1, 4'h0, ex(1,0,0,0,0,0,1, 5'd0, 4'h9));
    tbl[21] = mk(1, 5'd7, 0, 0, 1, 4'hC, ex(0,0,0,0,0,1,0, 5'd7, 4'h9));
    tbl[22] = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(1,0,0,0,0,0,1, 5'd0, 4'hC));
    tbl[23] = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(1,0,0,0,0,0,0, 5'd0, 4'hC));

    // Full load+store command right after a mid-operation reset
    post[0] = mk(1, 5'd1, 1, 1, 1, 4'h0, ex(1,0,0,0,0,0,0, 5'd0, 4'h0));
    post[1] = mk(0, 5'd0, 0, 0, 1, 4'h0, ex(0,1,0,0,0,0,0, 5'd0, 4'h0));
    post[2] = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(0,1,1,1,0,0,0, 5'd0, 4'h0));
    post[3] = mk(0, 5'd0, 0, 0, 0, 4'h6, ex(0,1,0,0,0,1,0, 5'd1, 4'h0));
    post[4] = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(0,1,1,0,1,0,0, 5'd0, 4'h6));
    post[5] = mk(0, 5'd0, 0, 0, 0, 4'h0, ex(1,0,0,0,0,0,1, 5'd0, 4'h6));

    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_state", ex(1,0,0,0,0,0,0, 5'd0, 4'h0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) run(tbl[i], $sformatf("row%0d", i));

    // Reset asserted mid-EXEC with status_q holding a nonzero value
    run(mk(1, 5'd5, 0, 0, 0, 4'h0, ex(1,0,0,0,0,0,0, 5'd0, 4'hC)), "rst_accept");
    cmd_valid = 1'b0;
    alu_status = 4'hF;
    #1;
    check("rst_in_exec", ex(0,0,0,0,0,1,0, 5'd5, 4'hC));
    reset = 1'b1;
    #1;
    check("rst_async", ex(1,0,0,0,0,0,0, 5'd0, 4'h0));
    @(posedge clk);
    @(negedge clk);
    check("rst_held", ex(1,0,0,0,0,0,0, 5'd0, 4'h0));
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run(post[i], $sformatf("post_rst%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
